// File: rtl/neuron_1input_backprop.sv
// Backward pass + SGD update for the single-input ReLU neuron f = relu(w1*x1 + b).
// Three-stage pipeline: S1 captures operands, S2 forms products, S3 applies the step.
module neuron_1input_backprop #(
  parameter int LR_SHIFT = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               valid_in,
  input  logic signed [31:0] x1,
  input  logic signed [31:0] z,
  input  logic signed [31:0] grad_f,
  input  logic               load,
  input  logic signed [31:0] load_w1,
  input  logic signed [31:0] load_b,
  output logic signed [31:0] w1_out,
  output logic signed [31:0] b_out,
  output logic signed [31:0] grad_x,
  output logic               valid_out,
  output logic        [15:0] update_count
);

  localparam int STAGES = 3;

  // vld_pipe[1]=v1, [2]=v2, [3]=valid_out
  logic [STAGES:1]    vld_pipe;
  logic signed [31:0] grad_z;
  logic signed [31:0] x1_s1, gz_s1, wsnap_s1;
  logic signed [31:0] dw_s2, db_s2, gx_s2;
  logic               upd;

  // ReLU derivative: strictly positive pre-activation passes the gradient
  assign grad_z    = (z > 32'sd0) ? grad_f : 32'sd0;
  assign upd       = enable && vld_pipe[2];
  assign valid_out = vld_pipe[STAGES];

  // valid shift register; frozen while enable is low
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       vld_pipe <= '0;
    else if (enable) vld_pipe <= {vld_pipe[STAGES-1:1], valid_in};
  end

  // S1/S2 datapath; w_snap is the weight seen at acceptance (may be stale by in-flight updates)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x1_s1    <= '0;
      gz_s1    <= '0;
      wsnap_s1 <= '0;
      dw_s2    <= '0;
      db_s2    <= '0;
      gx_s2    <= '0;
    end else if (enable) begin
      x1_s1    <= x1;
      gz_s1    <= grad_z;
      wsnap_s1 <= w1_out;
      dw_s2    <= gz_s1 * x1_s1;
      db_s2    <= gz_s1;
      gx_s2    <= gz_s1 * wsnap_s1;
    end
  end

  // S3 gradient output; holds the last sample's value otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset)    grad_x <= '0;
    else if (upd) grad_x <= gx_s2;
  end

  // trainable registers; load overrides an update landing on the same edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w1_out <= '0;
      b_out  <= '0;
    end else if (load) begin
      w1_out <= load_w1;
      b_out  <= load_b;
    end else if (upd) begin
      w1_out <= w1_out - (dw_s2 >>> LR_SHIFT);
      b_out  <= b_out  - (db_s2 >>> LR_SHIFT);
    end
  end

  // saturating count of applied updates (counts even when load wins)
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              update_count <= '0;
    else if (upd && update_count != 16'hFFFF) update_count <= update_count + 16'd1;
  end

endmodule
